// File: rtl/vedic_mult_pkg.sv
// rtl/vedic_mult_pkg.sv - shared widths and pipeline latency for the 4x4 Vedic multiplier
// LATENCY follows VEDIC_MULT_INREG_EN (2 with the input register stage, 1 without).
package vedic_mult_pkg;

    localparam int OPND_W = 4;
    localparam int PROD_W = 8;

`ifdef VEDIC_MULT_INREG_EN
    localparam int LATENCY = 2;
`else
    localparam int LATENCY = 1;
`endif

endpackage

// File: rtl/vedic4_array.sv
// rtl/vedic4_array.sv - combinational 4x4 Urdhva-Tiryagbhyam array (AND partial products, HA/FA column reduction)
module vedic4_array
    import vedic_mult_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [PROD_W-1:0] p
);

    logic [OPND_W-1:0] pp [OPND_W];   // pp[i][j] = a[i] & b[j]

    always_comb begin
        for (int i = 0; i < OPND_W; i++) begin
            for (int j = 0; j < OPND_W; j++) begin
                pp[i][j] = a[i] & b[j];
            end
        end
    end

    logic c1;
    logic s2a, c2a, c2b;
    logic s3a, c3a, s3b, c3b, c3c;
    logic s4a, c4a, s4b, c4b, c4c;
    logic s5a, c5a, c5b;

    assign p[0] = pp[0][0];

    vedic_ha u_ha1  (.x(pp[1][0]), .y(pp[0][1]), .s(p[1]), .c(c1));

    vedic_fa u_fa2a (.x(pp[2][0]), .y(pp[1][1]), .z(pp[0][2]), .s(s2a), .c(c2a));
    vedic_ha u_ha2b (.x(s2a), .y(c1), .s(p[2]), .c(c2b));

    vedic_fa u_fa3a (.x(pp[3][0]), .y(pp[2][1]), .z(pp[1][2]), .s(s3a), .c(c3a));
    vedic_ha u_ha3b (.x(s3a), .y(pp[0][3]), .s(s3b), .c(c3b));
    vedic_fa u_fa3c (.x(s3b), .y(c2a), .z(c2b), .s(p[3]), .c(c3c));

    vedic_fa u_fa4a (.x(pp[3][1]), .y(pp[2][2]), .z(pp[1][3]), .s(s4a), .c(c4a));
    vedic_ha u_ha4b (.x(s4a), .y(c3c), .s(s4b), .c(c4b));
    vedic_fa u_fa4c (.x(s4b), .y(c3a), .z(c3b), .s(p[4]), .c(c4c));

    vedic_fa u_fa5a (.x(c4a), .y(pp[2][3]), .z(pp[3][2]), .s(s5a), .c(c5a));
    vedic_fa u_fa5b (.x(s5a), .y(c4b), .z(c4c), .s(p[5]), .c(c5b));

    // 15*15 fits in 8 bits, so the col6 carry is the final product bit.
    vedic_fa u_fa6  (.x(c5a), .y(c5b), .z(pp[3][3]), .s(p[6]), .c(p[7]));

endmodule

// File: rtl/vedic_fa.sv
// rtl/vedic_fa.sv - full-adder leaf cell
module vedic_fa (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);

    assign s = x ^ y ^ z;
    assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/vedic_ha.sv
// rtl/vedic_ha.sv - half-adder leaf cell
module vedic_ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/vedic_mult4x4.sv
// rtl/vedic_mult4x4.sv - registered 4x4 Vedic multiplier stage with valid pipeline
// VEDIC_MULT_INREG_EN adds an input register stage (latency 2 instead of 1).
module vedic_mult4x4
    import vedic_mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic              out_valid,
    output logic [PROD_W-1:0] p
);

    logic              arr_valid;
    logic [OPND_W-1:0] arr_a;
    logic [OPND_W-1:0] arr_b;
    logic [PROD_W-1:0] arr_p;

`ifdef VEDIC_MULT_INREG_EN
    logic              in_valid_r;
    logic [OPND_W-1:0] a_r;
    logic [OPND_W-1:0] b_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_valid_r <= 1'b0;
            a_r        <= '0;
            b_r        <= '0;
        end else begin
            in_valid_r <= in_valid;
            a_r        <= a;
            b_r        <= b;
        end
    end

    assign arr_valid = in_valid_r;
    assign arr_a     = a_r;
    assign arr_b     = b_r;
`else
    assign arr_valid = in_valid;
    assign arr_a     = a;
    assign arr_b     = b;
`endif

    vedic4_array u_array (
        .a (arr_a),
        .b (arr_b),
        .p (arr_p)
    );

    // p keeps the last product across idle cycles; only out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            p         <= '0;
        end else begin
            out_valid <= arr_valid;
            if (arr_valid) begin
                p <= arr_p;
            end
        end
    end

endmodule

// File: tb/tb_vedic_mult4x4.sv
// tb/tb_vedic_mult4x4.sv - self-checking bench for vedic_mult4x4 against an arithmetic reference model
module tb_vedic_mult4x4;
    import vedic_mult_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic [7:0] p;

    int errors = 0;
    int checks = 0;

    bit [8:0]   hist[$];   // {valid, a*b} per issued cycle, aged LATENCY cycles
    logic [7:0] exp_p;

    vedic_mult4x4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .p         (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < LATENCY - 1; i++) hist.push_back(9'd0);
        exp_p = 8'h00;
    endtask

    // Called at a negedge: drive, let one rising edge pass, check at the next negedge.
    task automatic step(input string tag, input bit v, input logic [3:0] ta, input logic [3:0] tb_v);
        bit [8:0] e;
        int prod;
        prod     = int'(ta) * int'(tb_v);
        in_valid = v;
        a        = ta;
        b        = tb_v;
        hist.push_back({v, prod[7:0]});
        @(posedge clk);
        @(negedge clk);
        e = hist.pop_front();
        if (e[8]) exp_p = e[7:0];
        check({tag, "_ov"}, 32'(out_valid), 32'(e[8]));
        check({tag, "_p"}, 32'(p), 32'(exp_p));
    endtask

    // Issue one operand pair, drain the pipeline, then compare against a fixed constant.
    task automatic corner(input string tag, input logic [3:0] ta, input logic [3:0] tb_v, input logic [7:0] want);
        step(tag, 1'b1, ta, tb_v);
        for (int i = 1; i < LATENCY; i++) step({tag, "_drain"}, 1'b0, 4'd0, 4'd0);
        check({tag, "_const"}, 32'(p), 32'(want));
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 4'd0;
        b        = 4'd0;
        model_reset();

        #2;
        check("rst_async_p", 32'(p), 32'h00);
        check("rst_async_ov", 32'(out_valid), 32'h0);
        in_valid = 1'b1;
        a        = 4'd15;
        b        = 4'd15;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hold_p", 32'(p), 32'h00);
        check("rst_hold_ov", 32'(out_valid), 32'h0);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        corner("c_15x15", 4'd15, 4'd15, 8'hE1);
        corner("c_0x13",  4'd0,  4'd13, 8'h00);
        corner("c_1x9",   4'd1,  4'd9,  8'h09);
        corner("c_10x12", 4'd10, 4'd12, 8'h78);
        corner("c_7x7",   4'd7,  4'd7,  8'h31);
        corner("c_15x1",  4'd15, 4'd1,  8'h0F);

        step("stream0", 1'b1, 4'd3,  4'd5);
        step("stream1", 1'b1, 4'd6,  4'd9);
        step("stream2", 1'b1, 4'd11, 4'd13);
        for (int i = 1; i < LATENCY; i++) step("stream_drain", 1'b0, 4'd0, 4'd0);
        check("stream_last_const", 32'(p), 32'd143);

        corner("hold_12x12", 4'd12, 4'd12, 8'h90);
        step("idle", 1'b0, 4'd5, 4'd5);
        check("idle_ov_const", 32'(out_valid), 32'h0);
        check("idle_p_const", 32'(p), 32'h90);

        // Reset pulse mid-stream, asserted away from any clock edge.
        step("pre_rst0", 1'b1, 4'd9, 4'd8);
        in_valid = 1'b1;
        a        = 4'd13;
        b        = 4'd11;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_p", 32'(p), 32'h00);
        check("midrst_ov", 32'(out_valid), 32'h0);
        @(negedge clk);
        check("midrst_edge_p", 32'(p), 32'h00);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        model_reset();
        step("post_rst_idle", 1'b0, 4'd3, 4'd3);

        for (int i = 0; i < 256; i++) begin
            step("exh", 1'b1, 4'(i >> 4), 4'(i));
        end
        for (int i = 0; i < 100; i++) begin
            step("rnd", ($urandom_range(3, 0) != 0), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
        end
        for (int i = 0; i < LATENCY; i++) step("tail", 1'b0, 4'd0, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
